// File: rtl/hcsr04_pkg.sv
// Shared types and default constants for the HC-SR04 ranging front end.
//   ranger_state_t : ranger FSM state encoding
//   DEF_*          : default timing/width parameters for a 40 MHz clock
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } ranger_state_t;

  localparam int unsigned DEF_US_DIV    = 40;
  localparam int unsigned DEF_TRIG_US   = 20;
  localparam int unsigned DEF_PERIOD_US = 60000;
  localparam int unsigned DEF_MAX_US    = 3552;
  localparam int unsigned DEF_W         = 12;

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond tick prescaler.
//   clk   : system clock
//   reset : asynchronous, active-high
//   run   : count while high; counter is held at 0 otherwise
//   tick  : one-clk pulse every US_DIV clocks while running
module us_tick_gen #(
  parameter int unsigned US_DIV = 40
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(US_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cnt <= '0;
    else if (!run)          cnt <= '0;
    else if (cnt == LAST)   cnt <= '0;
    else                    cnt <= cnt + CW'(1);
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ranging stage: periodic trigger, echo width timing in microseconds,
// one saturated distance sample per measurement period.
//   clk        : system clock
//   reset      : asynchronous, active-high
//   enable     : run periodic measurements
//   echo       : sensor echo pin (asynchronous)
//   trig       : sensor trigger pin
//   dist_us    : last published echo width in us, saturated at MAX_US
//   dist_valid : one-clk strobe when dist_us/no_echo/overrange update
//   no_echo    : last sample saw no echo rise within the period
//   overrange  : last sample saturated or echo still high at period end
//   busy       : FSM not idle
module hcsr04_ranger
  import hcsr04_pkg::*;
#(
  parameter int unsigned US_DIV    = DEF_US_DIV,
  parameter int unsigned TRIG_US   = DEF_TRIG_US,
  parameter int unsigned PERIOD_US = DEF_PERIOD_US,
  parameter int unsigned MAX_US    = DEF_MAX_US,
  parameter int unsigned W         = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         echo,
  output logic         trig,
  output logic [W-1:0] dist_us,
  output logic         dist_valid,
  output logic         no_echo,
  output logic         overrange,
  output logic         busy
);

  localparam logic [W-1:0] MAX_CNT    = W'(MAX_US);
  localparam logic [15:0]  PERIOD_END = 16'(PERIOD_US - 1);
  localparam logic [15:0]  TRIG_END   = 16'(TRIG_US - 1);

  ranger_state_t state;
  logic          echo_s1, echo_s2, echo_s3;
  logic          echo_rise, echo_fall;
  logic          run, tick, period_end, trig_done;
  logic [15:0]   period_cnt;
  logic [W-1:0]  echo_cnt;

  // Two-flop synchronizer plus a third copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_s3 <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
    end
  end

  assign echo_rise = echo_s2 & ~echo_s3;
  assign echo_fall = ~echo_s2 & echo_s3;

  assign run = enable || (state != IDLE);

  us_tick_gen #(.US_DIV(US_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  assign period_end = tick && (period_cnt == PERIOD_END);
  assign trig_done  = tick && (period_cnt == TRIG_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      trig       <= 1'b0;
      dist_us    <= '0;
      dist_valid <= 1'b0;
      no_echo    <= 1'b0;
      overrange  <= 1'b0;
      busy       <= 1'b0;
      period_cnt <= '0;
      echo_cnt   <= '0;
    end else begin
      dist_valid <= 1'b0;
      if (tick) period_cnt <= period_cnt + 16'd1;

      unique case (state)
        IDLE: begin
          if (enable && tick) begin
            state      <= TRIG;
            trig       <= 1'b1;
            busy       <= 1'b1;
            period_cnt <= '0;
          end
        end
        TRIG: begin
          if (trig_done) begin
            state <= WAIT_RISE;
            trig  <= 1'b0;
          end
        end
        WAIT_RISE: begin
          if (period_end) begin
            dist_us    <= MAX_CNT;
            no_echo    <= 1'b1;
            overrange  <= 1'b0;
            dist_valid <= 1'b1;
          end else if (echo_rise) begin
            echo_cnt <= '0;
            state    <= MEASURE;
          end
        end
        MEASURE: begin
          // A fall on the period-end tick publishes the measured count.
          if (echo_fall) begin
            dist_us    <= echo_cnt;
            no_echo    <= 1'b0;
            overrange  <= (echo_cnt == MAX_CNT);
            dist_valid <= 1'b1;
            state      <= HOLDOFF;
          end else if (period_end) begin
            dist_us    <= MAX_CNT;
            no_echo    <= 1'b0;
            overrange  <= 1'b1;
            dist_valid <= 1'b1;
          end else if (tick && echo_s2 && (echo_cnt != MAX_CNT)) begin
            echo_cnt <= echo_cnt + W'(1);
          end
        end
        HOLDOFF: ;
        default: state <= IDLE;
      endcase

      // Period-end transition is shared by WAIT_RISE, MEASURE and HOLDOFF and
      // overrides any state change made above in the same cycle.
      if (period_end && (state != IDLE) && (state != TRIG)) begin
        if (enable) begin
          state      <= TRIG;
          trig       <= 1'b1;
          period_cnt <= '0;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hcsr04_ranger.sv
module tb_hcsr04_ranger;

  localparam int US_DIV = 4;
  localparam int TRIG_US = 20;
  localparam int PERIOD_US = 2000;
  localparam int MAX_US = 1500;
  localparam int W = 12;
  localparam int PERIOD_CLK = PERIOD_US * US_DIV;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         echo;
  logic         trig;
  logic [W-1:0] dist_us;
  logic         dist_valid;
  logic         no_echo;
  logic         overrange;
  logic         busy;

  hcsr04_ranger #(
    .US_DIV(US_DIV), .TRIG_US(TRIG_US), .PERIOD_US(PERIOD_US),
    .MAX_US(MAX_US), .W(W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo(echo),
    .trig(trig), .dist_us(dist_us), .dist_valid(dist_valid),
    .no_echo(no_echo), .overrange(overrange), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int strobes = 0;
  int cyc_n = 0;

  // high_us: >0 echo width, 0 no echo, -1 echo rises and never falls
  typedef struct {
    int rise_us;
    int high_us;
    int lo;
    int hi;
    int ne;
    int ov;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Advance one clock, sampling on the falling edge and counting strobes.
  task automatic step();
    @(negedge clk);
    cyc_n++;
    if (dist_valid) strobes++;
  endtask

  task automatic wait_trig(input logic lvl, input int bound, input string name);
    int n = 0;
    while (trig !== lvl && n < bound) begin
      step();
      n++;
    end
    check(name, int'(trig), int'(lvl));
  endtask

  task automatic wait_valid(input int bound, input string name);
    int n = 0;
    while (dist_valid !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    check(name, int'(dist_valid), 1);
  endtask

  initial begin
    int p0, c0, c1, c2, hi, n;
    logic trig_seen;

    vecs[0] = '{100, 1000, 999, 1001, 0, 0};
    vecs[1] = '{50, 1900, MAX_US, MAX_US, 0, 1};
    vecs[2] = '{100, -1, MAX_US, MAX_US, 0, 1};
    vecs[3] = '{0, 0, MAX_US, MAX_US, 1, 0};

    reset = 1'b1;
    enable = 1'b0;
    echo = 1'b0;
    repeat (3) step();
    check("rst_trig", int'(trig), 0);
    check("rst_dist", int'(dist_us), 0);
    check("rst_valid", int'(dist_valid), 0);
    check("rst_no_echo", int'(no_echo), 0);
    check("rst_overrange", int'(overrange), 0);
    check("rst_busy", int'(busy), 0);

    reset = 1'b0;
    step();
    enable = 1'b1;
    wait_trig(1'b1, 40, "first_trig");
    check("busy_run", int'(busy), 1);

    for (int i = 0; i < 4; i++) begin
      p0 = strobes;
      wait_trig(1'b0, 200, $sformatf("v%0d_trig_fall", i));
      echo = 1'b0;
      if (vecs[i].high_us != 0) begin
        repeat (vecs[i].rise_us * US_DIV) step();
        echo = 1'b1;
        if (vecs[i].high_us > 0) begin
          repeat (vecs[i].high_us * US_DIV) step();
          echo = 1'b0;
        end
      end
      wait_valid(PERIOD_CLK + 200, $sformatf("v%0d_strobe", i));
      check_rng($sformatf("v%0d_dist", i), int'(dist_us), vecs[i].lo, vecs[i].hi);
      check($sformatf("v%0d_no_echo", i), int'(no_echo), vecs[i].ne);
      check($sformatf("v%0d_overrange", i), int'(overrange), vecs[i].ov);
      wait_trig(1'b1, PERIOD_CLK + 200, $sformatf("v%0d_next_trig", i));
      check($sformatf("v%0d_strobe_count", i), strobes - p0, 1);
    end

    // Trigger width and period with echo held low.
    p0 = strobes;
    c0 = cyc_n;
    hi = 0;
    while (trig == 1'b1 && hi < 200) begin
      hi++;
      step();
    end
    check("trig_high_clk", hi, TRIG_US * US_DIV);
    wait_trig(1'b1, PERIOD_CLK + 200, "period_trig");
    c1 = cyc_n;
    check("trig_period_clk", c1 - c0, PERIOD_CLK);
    check("noecho_valid_at_period_end", int'(dist_valid), 1);
    check("noecho_dist", int'(dist_us), MAX_US);
    check("noecho_flag", int'(no_echo), 1);
    check("noecho_overrange", int'(overrange), 0);
    check("noecho_strobe_count", strobes - p0, 1);

    // Synced fall lands on the period-end tick: echo high from clk 4001 to
    // 7998 after trig rise gives 999 counted ticks, published with normal status.
    p0 = strobes;
    repeat (4000) step();
    echo = 1'b1;
    repeat (3997) step();
    echo = 1'b0;
    repeat (3) step();
    c2 = cyc_n;
    check("coinc_valid", int'(dist_valid), 1);
    check("coinc_dist", int'(dist_us), 999);
    check("coinc_no_echo", int'(no_echo), 0);
    check("coinc_overrange", int'(overrange), 0);
    check("coinc_trig", int'(trig), 1);
    check("coinc_strobe_count", strobes - p0, 1);

    // Enable drops mid-MEASURE: publish at fall, then idle at period end.
    p0 = strobes;
    wait_trig(1'b0, 200, "en_trig_fall");
    repeat (400) step();
    echo = 1'b1;
    repeat (400) step();
    enable = 1'b0;
    repeat (400) step();
    echo = 1'b0;
    wait_valid(PERIOD_CLK, "en_strobe");
    check_rng("en_dist", int'(dist_us), 199, 201);
    check("en_no_echo", int'(no_echo), 0);
    check("en_overrange", int'(overrange), 0);
    step();
    check("en_busy_holdoff", int'(busy), 1);
    n = 0;
    while (cyc_n < c2 + PERIOD_CLK + 2 && n < PERIOD_CLK + 10) begin
      step();
      n++;
    end
    check("en_busy_idle", int'(busy), 0);
    trig_seen = 1'b0;
    repeat (2000) begin
      step();
      if (trig) trig_seen = 1'b1;
    end
    check("en_no_trig_after", int'(trig_seen), 0);
    check("en_strobe_count", strobes - p0, 1);
    check("en_dist_hold", int'(dist_us) >= 199 && int'(dist_us) <= 201, 1);

    // Reset asserted mid-TRIG aborts at once.
    enable = 1'b1;
    wait_trig(1'b1, 40, "rst_trig_rise");
    repeat (10) step();
    p0 = strobes;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_trig", int'(trig), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_dist", int'(dist_us), 0);
    check("mid_rst_no_echo", int'(no_echo), 0);
    check("mid_rst_overrange", int'(overrange), 0);
    repeat (3) step();
    check("mid_rst_no_strobe", strobes - p0, 0);
    enable = 1'b0;
    reset = 1'b0;
    repeat (20) step();
    check("post_rst_idle_trig", int'(trig), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hcsr04_ranger.md
# hcsr04_ranger

Front-end ranging stage for the HC-SR04 ultrasonic sensor. It generates the periodic trigger pulse, synchronizes and times the echo pulse in microseconds, and publishes one saturated distance sample per measurement period with a single-cycle valid strobe. It sits directly upstream of the boxcar averaging filter and replaces ad hoc trigger/echo counting in the top level.

## Interface
- `US_DIV`, 40: clk cycles per microsecond (40 MHz clk).
- `TRIG_US`, 20: trigger high time in µs.
- `PERIOD_US`, 60000: measurement period in µs, trigger rise to trigger rise.
- `MAX_US`, 3552: saturation value of the distance, in µs.
- `W`, 12: distance width; `MAX_US` < 2^W.
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `enable` in 1: run periodic measurements.
- `echo` in 1: sensor echo pin, asynchronous.
- `trig` out 1: sensor trigger pin.
- `dist_us` out W: last published echo width in µs, saturated.
- `dist_valid` out 1: one-clk strobe; `dist_us`/status updated this cycle.
- `no_echo` out 1: last sample had no echo rise within the period.
- `overrange` out 1: last sample saturated, or echo still high at period end.
- `busy` out 1: FSM not in IDLE.

## Operation
- `echo` passes through a 2-flop synchronizer. Rise and fall are detected against a third registered copy.
- A µs tick is a one-clk pulse when the prescaler equals `US_DIV-1`. The prescaler wraps to 0 and free-runs while enabled or busy.
- A 16-bit period counter runs in ticks. It clears on entry to TRIG.
- FSM states:
  - IDLE: `trig`=0. When `enable`=1, go to TRIG on the next tick.
  - TRIG: `trig`=1. After `TRIG_US` ticks, `trig`=0 and go to WAIT_RISE.
  - WAIT_RISE: on a synced rise, clear the echo counter and go to MEASURE.
  - MEASURE: on each tick with synced echo high, the echo counter increments, saturating at `MAX_US`. On a synced fall, publish and go to HOLDOFF.
  - HOLDOFF: wait for period end.
  - Period end is the tick where the period counter equals `PERIOD_US-1`. At period end, go to TRIG if `enable`=1, else go to IDLE.
- Period end while in WAIT_RISE: publish `dist_us`=`MAX_US`, `no_echo`=1, `overrange`=0.
- Period end while in MEASURE: publish `dist_us`=`MAX_US`, `overrange`=1, `no_echo`=0.
- Normal publish: `dist_us`=count. `overrange`=1 iff count == `MAX_US`. `no_echo`=0.
- Exactly one `dist_valid` per period while enabled. It never fires in IDLE.
- A synced echo rise outside WAIT_RISE is ignored. A synced fall outside MEASURE is ignored.
- Fall and period end in the same cycle: the fall wins. Publish the measured value with normal status, then go to TRIG or IDLE per `enable`.
- `enable` dropping mid-period: finish the period, publish, then go to IDLE.
- `dist_us`, `no_echo` and `overrange` hold their values between strobes.

## Timing
- Reset values:
  - All outputs 0 (`trig`, `dist_us`, `dist_valid`, `no_echo`, `overrange`, `busy`).
  - FSM in IDLE.
  - Prescaler, period counter, echo counter and synchronizer all 0.
- Reset mid-operation aborts immediately. `trig` drops asynchronously and no strobe is emitted.
- `trig` rises 1 clk after the tick that leaves IDLE or ends the period. It stays high for exactly `TRIG_US`×`US_DIV` clk.
- Echo latency: `echo` low sampled at clk edge k gives `dist_valid`=1 in the cycle after edge k+2 (3 clk). `dist_us` is valid in the same cycle.
- Measurement resolution is ±1 µs, because the tick phase is unrelated to the echo edges.
- Trigger period is `PERIOD_US`×`US_DIV` clk, exact while enabled.
- All outputs are registered. There is no combinational path from `echo` or `enable` to any output.

## Structure
- Package `hcsr04_pkg`:
  - `ranger_state_t` enum (IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF).
  - Default constants for `US_DIV`, `TRIG_US`, `PERIOD_US`, `MAX_US`, `W`.
- Sub-module `us_tick_gen`: parameter `US_DIV`; inputs `clk`, `reset`, `run`; output `tick`. Reused elsewhere.
- The synchronizer, FSM and counters stay inline in `hcsr04_ranger`.

## Test plan
All scenarios use `US_DIV`=4 and `PERIOD_US`=2000 to keep simulation short.
- Nominal echo: `enable`=1; echo rises 100 µs after `trig` falls and stays high 1000 µs -> one `dist_valid`, `dist_us` in 999..1001, `no_echo`=0, `overrange`=0.
- Saturation: echo high 1900 µs with `MAX_US`=1500 -> `dist_us`=1500, `overrange`=1, single strobe at echo fall.
- No echo: `echo` held 0 -> at each period end `dist_us`=`MAX_US`, `no_echo`=1; `trig` period exactly 8000 clk; `trig` high exactly 80 clk.
- Stuck echo: echo rises and never falls -> strobe at period end with `overrange`=1; next `trig` follows; the following period reports `no_echo`=1.
- Enable/reset: drop `enable` mid-MEASURE -> publish at fall, then IDLE with `busy`=0 and no further `trig`. Assert `reset` mid-TRIG -> `trig`=0 that cycle, all outputs 0, no strobe.
- Coincidence: force the synced echo fall on the period-end tick -> measured value published with normal status; exactly one strobe that period.
